// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: D/E forward selects and D stall from a shifting producer scoreboard plus MDU busy interlock.
// Outputs are combinational (no added latency); stall is the only flow control. HAZARD_STATS_EN adds stall counters.
module hazard_scoreboard #(
  parameter int NUM_STAGES = 3,
  parameter int REG_AW     = 5,
  parameter int TNEW_W     = 3,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int FWD_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] a1_D,
  input  logic [REG_AW-1:0] a2_D,
  input  logic [TNEW_W-1:0] tuse_a1_D,
  input  logic [TNEW_W-1:0] tuse_a2_D,
  input  logic [REG_AW-1:0] a3_D,
  input  logic [TNEW_W-1:0] tnew_D,
  input  logic              md_start_D,
  input  logic              md_is_div_D,
  input  logic              md_use_D,
  output logic [FWD_W-1:0]  fwd1_D,
  output logic [FWD_W-1:0]  fwd2_D,
  output logic [FWD_W-1:0]  fwd1_E,
  output logic [FWD_W-1:0]  fwd2_E,
  output logic              md_busy,
  output logic              stall
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       md_stall_cnt
`endif
);

  localparam int MdMax = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int MdW   = $clog2(MdMax + 1);

  typedef struct packed {
    logic [REG_AW-1:0] a3;
    logic [TNEW_W-1:0] tnew;
    logic [REG_AW-1:0] a1;
    logic [REG_AW-1:0] a2;
  } entry_t;

  // sb[0] is the E entry; sb[NUM_STAGES-1] is the last stage, still forwardable.
  entry_t            sb [NUM_STAGES];
  entry_t            newEntry;
  logic [MdW-1:0]    mdCnt;
  logic              mdInE;
  logic [REG_AW-1:0] srcAddr [4];
  logic              hit     [4];
  logic [FWD_W-1:0]  hitIdx  [4];
  logic [TNEW_W-1:0] hitTnew [4];
  logic              srcStall;
  logic              mdStall;
  logic              mdAccept;

  assign srcAddr[0] = a1_D;
  assign srcAddr[1] = a2_D;
  assign srcAddr[2] = sb[0].a1;
  assign srcAddr[3] = sb[0].a2;

  // Walk from the far end inward so the nearest matching producer wins; E sources skip their own entry.
  always_comb begin
    for (int s = 0; s < 4; s++) begin
      hit[s]     = 1'b0;
      hitIdx[s]  = '0;
      hitTnew[s] = '0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
        if ((s < 2 || i >= 1) && srcAddr[s] != '0 && sb[i].a3 == srcAddr[s]) begin
          hit[s]     = 1'b1;
          hitIdx[s]  = FWD_W'(i + 1);
          hitTnew[s] = sb[i].tnew;
        end
      end
    end
  end

  always_comb begin
    newEntry.a3   = a3_D;
    newEntry.tnew = tnew_D;
    newEntry.a1   = a1_D;
    newEntry.a2   = a2_D;
  end

  assign srcStall = (hit[0] && hitTnew[0] > tuse_a1_D) || (hit[1] && hitTnew[1] > tuse_a2_D);
  assign md_busy  = (mdCnt != '0);
  assign mdStall  = md_use_D && (md_busy || mdInE);
  assign stall    = srcStall || mdStall;
  assign mdAccept = md_start_D && !stall;

  assign fwd1_D = (hit[0] && hitTnew[0] == '0) ? hitIdx[0] : '0;
  assign fwd2_D = (hit[1] && hitTnew[1] == '0) ? hitIdx[1] : '0;
  assign fwd1_E = (hit[2] && hitTnew[2] == '0) ? hitIdx[2] : '0;
  assign fwd2_E = (hit[3] && hitTnew[3] == '0) ? hitIdx[3] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STAGES; i++) sb[i] <= '0;
      mdCnt <= '0;
      mdInE <= 1'b0;
    end else begin
      sb[0] <= stall ? '0 : newEntry;
      for (int i = 1; i < NUM_STAGES; i++) begin
        sb[i] <= entry_t'{
          a3:   sb[i-1].a3,
          tnew: (sb[i-1].tnew != '0) ? sb[i-1].tnew - TNEW_W'(1) : '0,
          a1:   sb[i-1].a1,
          a2:   sb[i-1].a2
        };
      end
      if (mdAccept) mdCnt <= md_is_div_D ? MdW'(DIV_CYCLES) : MdW'(MUL_CYCLES);
      else if (mdCnt != '0) mdCnt <= mdCnt - MdW'(1);
      mdInE <= mdAccept;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt    <= '0;
      md_stall_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (mdStall && !srcStall && md_stall_cnt != '1) md_stall_cnt <= md_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard: a reference model of in-flight producers feeds an expected-value queue that a monitor drains.
module tb_hazard_scoreboard;
  localparam int N = 3;
  localparam int MULC = 5;
  localparam int DIVC = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] a1_D, a2_D, a3_D;
  logic [2:0] tuse_a1_D, tuse_a2_D, tnew_D;
  logic       md_start_D, md_is_div_D, md_use_D;
  logic [1:0] fwd1_D, fwd2_D, fwd1_E, fwd2_E;
  logic       md_busy, stall;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, md_stall_cnt;
`endif

  hazard_scoreboard #(.NUM_STAGES(N), .REG_AW(5), .TNEW_W(3), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk(clk), .reset(reset),
    .a1_D(a1_D), .a2_D(a2_D), .tuse_a1_D(tuse_a1_D), .tuse_a2_D(tuse_a2_D),
    .a3_D(a3_D), .tnew_D(tnew_D),
    .md_start_D(md_start_D), .md_is_div_D(md_is_div_D), .md_use_D(md_use_D),
    .fwd1_D(fwd1_D), .fwd2_D(fwd2_D), .fwd1_E(fwd1_E), .fwd2_E(fwd2_E),
    .md_busy(md_busy), .stall(stall)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .md_stall_cnt(md_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Each accepted instruction remembers the edge that took it into E; its stage and remaining Tnew follow from age.
  typedef struct { int acc; logic [4:0] a3, a1, a2; int tnew0; } rec_t;
  typedef struct { logic [31:0] f1d, f2d, f1e, f2e, busy, stl, sc, msc; bit mdOnly; } exp_t;

  rec_t hist[$];
  exp_t q[$];
  int edges = 0, mdEnd = 0, mdAcc = -1, statStall = 0, statMd = 0;
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void clearModel();
    hist.delete();
    mdEnd = 0; mdAcc = -1; statStall = 0; statMd = 0;
  endfunction

  function automatic void lookup(input logic [4:0] a, input int lo, output int idx, output int tn);
    idx = 0; tn = 0;
    if (a == 5'd0) return;
    for (int i = lo; i <= N && idx == 0; i++)
      foreach (hist[k])
        if (edges - hist[k].acc + 1 == i && hist[k].a3 == a) begin
          idx = i;
          tn = hist[k].tnew0 - (edges - hist[k].acc);
          if (tn < 0) tn = 0;
        end
  endfunction

  function automatic exp_t evalModel();
    exp_t e;
    int i1, t1, i2, t2, ie1, te1, ie2, te2;
    logic [4:0] ea1 = 5'd0, ea2 = 5'd0;
    bit s1, s2, mdS, busy;
    foreach (hist[k]) if (edges == hist[k].acc) begin ea1 = hist[k].a1; ea2 = hist[k].a2; end
    lookup(a1_D, 1, i1, t1);
    lookup(a2_D, 1, i2, t2);
    lookup(ea1, 2, ie1, te1);
    lookup(ea2, 2, ie2, te2);
    s1 = (i1 != 0) && (t1 > int'(tuse_a1_D));
    s2 = (i2 != 0) && (t2 > int'(tuse_a2_D));
    busy = edges < mdEnd;
    mdS = md_use_D && (busy || mdAcc == edges);
    e.f1d = (i1 != 0 && t1 == 0) ? i1 : 0;
    e.f2d = (i2 != 0 && t2 == 0) ? i2 : 0;
    e.f1e = (ie1 != 0 && te1 == 0) ? ie1 : 0;
    e.f2e = (ie2 != 0 && te2 == 0) ? ie2 : 0;
    e.busy = busy;
    e.stl = s1 || s2 || mdS;
    e.mdOnly = mdS && !(s1 || s2);
    e.sc = statStall;
    e.msc = statMd;
    return e;
  endfunction

  function automatic void commit(input exp_t e);
    rec_t r;
    edges++;
    if (reset) begin clearModel(); return; end
    if (e.stl[0]) statStall++;
    if (e.mdOnly) statMd++;
    if (!e.stl[0]) begin
      r.acc = edges; r.a3 = a3_D; r.a1 = a1_D; r.a2 = a2_D; r.tnew0 = int'(tnew_D);
      hist.push_back(r);
      if (md_start_D) begin
        mdAcc = edges;
        mdEnd = edges + (md_is_div_D ? DIVC : MULC);
      end
    end
    while (hist.size() > 0 && edges - hist[0].acc + 1 > N) void'(hist.pop_front());
  endfunction

  task automatic setIn(input logic [4:0] a1, a2, a3, input int tu1, tu2, tn, input bit ms, md, mu);
    a1_D = a1; a2_D = a2; a3_D = a3;
    tuse_a1_D = 3'(tu1); tuse_a2_D = 3'(tu2); tnew_D = 3'(tn);
    md_start_D = ms; md_is_div_D = md; md_use_D = mu;
  endtask

  // Hold one D instruction until the model says it is accepted; counts stall cycles seen on the DUT.
  task automatic issue(input logic [4:0] a1, a2, a3, input int tu1, tu2, tn, input bit ms, md, mu, output int nStall);
    exp_t e;
    nStall = 0;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      setIn(a1, a2, a3, tu1, tu2, tn, ms, md, mu);
      e = evalModel();
      q.push_back(e);
      #1;
      if (stall === 1'b1) nStall++;
      @(posedge clk);
      commit(e);
      if (!e.stl[0]) return;
    end
    checks++; errors++;
    $display("FAIL issue_timeout: instruction still stalled after 64 cycles");
  endtask

  task automatic doReset(input bit checkNow);
    exp_t e;
    @(negedge clk);
    if (checkNow) chk("pre_rst_busy", {31'd0, md_busy}, 32'd1);
    reset = 1'b1;
    clearModel();
    e = evalModel();
    q.push_back(e);
    #1;
    if (checkNow) begin
      chk("rst_busy", {31'd0, md_busy}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_fwd1D", {30'd0, fwd1_D}, 32'd0);
      chk("rst_fwd1E", {30'd0, fwd1_E}, 32'd0);
    end
    @(posedge clk);
    commit(e);
    @(negedge clk);
    reset = 1'b0;
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    e = evalModel();
    q.push_back(e);
    @(posedge clk);
    commit(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("fwd1_D", {30'd0, fwd1_D}, e.f1d);
        chk("fwd2_D", {30'd0, fwd2_D}, e.f2d);
        chk("fwd1_E", {30'd0, fwd1_E}, e.f1e);
        chk("fwd2_E", {30'd0, fwd2_E}, e.f2e);
        chk("md_busy", {31'd0, md_busy}, e.busy);
        chk("stall", {31'd0, stall}, e.stl);
`ifdef HAZARD_STATS_EN
        chk("stall_cnt", stall_cnt, e.sc);
        chk("md_stall_cnt", md_stall_cnt, e.msc);
`endif
      end
    end
  end

  initial begin : driver
    int ns;
    reset = 1'b1;
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    doReset(1'b0);

    for (int r = 0; r < 4; r++) begin
      issue(5'd0, 5'd0, 5'd8, 0, 0, 2, 0, 0, 0, ns);
      issue(5'd8, 5'd0, 5'd9, 1, 3, 1, 0, 0, 0, ns);
      chk("lw_use_stall", ns, 1);
    end
`ifdef HAZARD_STATS_EN
    #1;
    chk("stats_stall_cnt", stall_cnt, 32'd4);
    chk("stats_md_stall_cnt", md_stall_cnt, 32'd0);
`endif

    issue(5'd0, 5'd0, 5'd11, 0, 0, 1, 0, 0, 0, ns);
    issue(5'd11, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, ns);
    chk("addu_beq_stall", ns, 1);

    issue(5'd0, 5'd0, 5'd10, 0, 0, 0, 0, 0, 0, ns);
    issue(5'd0, 5'd0, 5'd10, 0, 0, 0, 0, 0, 0, ns);
    issue(5'd10, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, ns);
    chk("two_writers_stall", ns, 0);

    issue(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 1, ns);
    issue(5'd0, 5'd0, 5'd12, 0, 0, 1, 0, 0, 1, ns);
    chk("div_mflo_stall", ns, 10);

    issue(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 1, ns);
    issue(5'd0, 5'd0, 5'd13, 0, 0, 2, 0, 0, 0, ns);
    issue(5'd13, 5'd0, 5'd14, 3, 3, 1, 0, 0, 0, ns);
    doReset(1'b1);

    for (int k = 0; k < 400; k++) begin
      bit ms;
      ms = ($urandom_range(0, 15) == 0);
      issue(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            ms, 1'($urandom_range(0, 1)), ms | ($urandom_range(0, 7) == 0), ns);
    end

    for (int i = 0; i < 8 && q.size() > 0; i++) @(negedge clk);
    #3;
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d expected entries never compared", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
